irq_arbiter: RTL and testbench
==============================

// Module: irq_arbiter
// PURPOSE
//  Shares the CPU's single irq / reset_irq pair between NUM_SRC device request lines (keyboard, vga, timers).
//  Edge-detects requests into a pending register, applies a software mask and fixed priority (src 0 highest),
//  raises cpu_irq and supplies the handler vector. Holds off further interrupts until software writes EOI.
//  Sits between the device drivers and datapath/controlpath. Its registers are memory-mapped on the io bus.
// PARAMETERS
//  NUM_SRC     4         number of request sources (1..8)
//  BASE_ADDR   16'hFFF0  address of register 0; registers occupy BASE_ADDR..BASE_ADDR+3
//  VEC_BASE    16'h0100  vector address of source 0
//  VEC_STRIDE  16'h0010  vector spacing between consecutive sources
// PORTS
//  clock         in   1        system clock
//  reset         in   1        synchronous, active-high reset
//  src_irq       in   NUM_SRC  device request lines, level; a rising edge posts a request
//  waddr         in   16       io write address
//  wdata         in   16       io write data
//  wenable       in   1        io write strobe, sampled on clock
//  raddr         in   16       io read address
//  rdata         out  16       io read data, combinational from raddr
//  cpu_irq       out  1        interrupt request to controlpath, registered
//  cpu_reset_irq in   1        one-cycle acknowledge from controlpath when it vectors
//  irq_vector    out  16       handler address for the granted source
//  irq_id        out  3        granted source index
//  in_service    out  1        high while a handler runs (between ack and EOI)
// BEHAVIOUR
//  Registers (offset from BASE_ADDR):
//   +0 MASK: R/W, bit i=1 enables source i. Bits >= NUM_SRC read 0.
//   +1 PEND: R, write-1-to-clear.
//   +2 ID: R, {13'b0, irq_id}.
//   +3 EOI: W; any write ends service. Reads return 0.
//   Any other raddr: rdata=0. Writes land only when wenable=1 at the clock edge.
//  Edge detect: src_prev <= src_irq each cycle.
//   pend[i] is set at an edge where src_irq[i]=1 and src_prev[i]=0.
//   Set beats a same-cycle W1C or ack clear of the same bit.
//  FSM IDLE -> ASSERT -> SERVICE -> IDLE:
//   IDLE: if (pend & mask) != 0, latch id = lowest set index and go to ASSERT.
//   ASSERT: cpu_irq=1.
//    - On cpu_reset_irq=1: clear pend[id] and go to SERVICE.
//    - If pend[id] or mask[id] becomes 0 first (W1C or MASK write): go to IDLE. id is not re-arbitrated in ASSERT.
//   SERVICE: cpu_irq=0. An EOI write returns to IDLE. New edges still set pend but are not granted.
//   cpu_reset_irq outside ASSERT is ignored.
//  Latency: src rises before edge k -> pend set after k -> ASSERT and cpu_irq=1 after k+1.
//   After ack at edge a: cpu_irq=0 and in_service=1 after a.
//   After EOI at edge e: IDLE after e; a waiting request gives cpu_irq=1 after e+1.
//  irq_vector = VEC_BASE + irq_id*VEC_STRIDE, truncated to 16 bits (wraps). Valid in ASSERT and SERVICE; 0 in IDLE.
//  in_service = (state==SERVICE).
//  Reset values: state=IDLE, mask=0, pend=0, src_prev=0, id=0, cpu_irq=0, in_service=0, irq_vector=0.
//   Reset mid-ASSERT or mid-SERVICE drops everything in the same cycle.
//   A source held high across reset does not post a request: src_prev resets to 0, but edge detection is suppressed while reset=1 and in the first cycle after it.
// TESTING
//  mask=4'hF, pulse src 2 -> cpu_irq=1 two cycles later, irq_vector=16'h0120, ID reads 2.
//  src 1 and src 3 rise on the same cycle -> grant id 1. Ack then EOI -> id 3 granted, vector 16'h0130.
//  mask=4'b1110, pulse src 0 -> no cpu_irq, PEND=1. Write MASK=1 -> cpu_irq after 1 cycle.
//  In SERVICE, pulse src 0 -> cpu_irq stays 0 until EOI, then asserts with id 0.
//  In ASSERT, W1C PEND bit of id -> cpu_irq=0 next cycle, state IDLE, no ack needed.
//  Reset pulsed in SERVICE with src_irq held high -> all outputs 0, PEND=0, no request after reset.

Source files
------------

// File: rtl/irq_arbiter.sv
// irq_arbiter
//   Shares the CPU's single interrupt request / acknowledge pair between
//   NUM_SRC device request lines. Rising edges on src_irq post requests into
//   a pending register. A software mask and fixed priority (source 0 highest)
//   select one source. That source is presented to the CPU with its handler
//   vector. No further source is granted until software writes EOI.
//
// Ports
//   clock          system clock
//   reset          synchronous, active-high reset
//   src_irq        device request lines (level; rising edge posts a request)
//   waddr/wdata    io bus write address / data
//   wenable        io bus write strobe
//   raddr          io bus read address
//   rdata          io bus read data, combinational from raddr
//   cpu_irq        interrupt request to the controlpath
//   cpu_reset_irq  one-cycle acknowledge from the controlpath
//   irq_vector     handler address of the granted source (0 while idle)
//   irq_id         granted source index
//   in_service     high between acknowledge and EOI
//
// Register map (offset from BASE_ADDR)
//   +0 MASK  R/W   bit i enables source i
//   +1 PEND  R/W1C pending requests
//   +2 ID    R     granted source index
//   +3 EOI   W     any write ends service; reads 0
module irq_arbiter #(
  parameter int          NUM_SRC    = 4,
  parameter logic [15:0] BASE_ADDR  = 16'hFFF0,
  parameter logic [15:0] VEC_BASE   = 16'h0100,
  parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [15:0]        waddr,
  input  logic [15:0]        wdata,
  input  logic               wenable,
  input  logic [15:0]        raddr,
  output logic [15:0]        rdata,
  output logic               cpu_irq,
  input  logic               cpu_reset_irq,
  output logic [15:0]        irq_vector,
  output logic [2:0]         irq_id,
  output logic               in_service
);

  localparam logic [15:0] ADDR_MASK = BASE_ADDR;
  localparam logic [15:0] ADDR_PEND = BASE_ADDR + 16'd1;
  localparam logic [15:0] ADDR_ID   = BASE_ADDR + 16'd2;
  localparam logic [15:0] ADDR_EOI  = BASE_ADDR + 16'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_SRC-1:0]   mask_reg, mask_next;
  logic [NUM_SRC-1:0]   pend_reg, pend_next;
  logic [NUM_SRC-1:0]   src_prev_reg;
  logic                 edge_arm_reg;
  logic [2:0]           id_reg, id_next;

  logic                 wr_mask, wr_pend, wr_eoi;
  logic [NUM_SRC-1:0]   w1c;
  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   id_sel;
  logic [NUM_SRC-1:0]   ack_clr;
  logic [NUM_SRC-1:0]   req;
  logic [2:0]           grant_id;
  logic                 ack;
  logic                 id_still_pending;
  logic                 id_still_enabled;

  // Only the low NUM_SRC data bits reach a register; the rest is ignored.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata};

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign wr_mask = wenable && (waddr == ADDR_MASK);
  assign wr_pend = wenable && (waddr == ADDR_PEND);
  assign wr_eoi  = wenable && (waddr == ADDR_EOI);
  assign w1c     = wr_pend ? wdata[NUM_SRC-1:0] : '0;

  // Edge detection is held off for the first cycle after reset so that a
  // line already high when reset releases does not look like a new request.
  assign rise = src_irq & ~src_prev_reg & {NUM_SRC{edge_arm_reg}};

  // Acknowledge only counts while a request is actually being presented.
  assign ack = cpu_reset_irq && (state_reg == ST_ASSERT);

  assign mask_next = wr_mask ? wdata[NUM_SRC-1:0] : mask_reg;
  assign req       = pend_reg & mask_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign id_sel[gi]    = (id_reg == 3'(gi));
      assign ack_clr[gi]   = ack && id_sel[gi];
      // A new edge wins over a same-cycle software or acknowledge clear.
      assign pend_next[gi] = rise[gi] | (pend_reg[gi] & ~w1c[gi] & ~ack_clr[gi]);
    end
  endgenerate

  // Look at the values the pending/mask bits are about to take, so a W1C or
  // mask write withdraws the request at the same edge that performs it.
  assign id_still_pending = |(pend_next & id_sel);
  assign id_still_enabled = |(mask_next & id_sel);

  // Fixed priority: lowest index wins, so scan from the top down.
  always_comb begin
    grant_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) grant_id = 3'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      mask_reg     <= '0;
      pend_reg     <= '0;
      src_prev_reg <= '0;
      edge_arm_reg <= 1'b0;
    end else begin
      mask_reg     <= mask_next;
      pend_reg     <= pend_next;
      src_prev_reg <= src_irq;
      edge_arm_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          id_next    = grant_id;
          state_next = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        // The granted id is held; if it is withdrawn we fall back to IDLE
        // and arbitrate afresh from there.
        if (cpu_reset_irq) begin
          state_next = ST_SERVICE;
        end else if (!id_still_pending || !id_still_enabled) begin
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (wr_eoi) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    cpu_irq    = (state_reg == ST_ASSERT);
    in_service = (state_reg == ST_SERVICE);
    irq_id     = id_reg;
    irq_vector = '0;
    if (state_reg != ST_IDLE) begin
      // 16-bit context: the product and sum wrap naturally.
      irq_vector = VEC_BASE + VEC_STRIDE * {13'b0, id_reg};
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (raddr)
      ADDR_MASK: rdata = 16'(mask_reg);
      ADDR_PEND: rdata = 16'(pend_reg);
      ADDR_ID:   rdata = {13'b0, id_reg};
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Testbench for irq_arbiter: directed vector table, a few hand-written
// corner sequences and a randomized run against a rule-level model.
module tb_irq_arbiter;

  localparam logic [15:0] A_MASK = 16'hFFF0;
  localparam logic [15:0] A_PEND = 16'hFFF1;
  localparam logic [15:0] A_ID   = 16'hFFF2;
  localparam logic [15:0] A_EOI  = 16'hFFF3;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  src_irq;
  logic [15:0] waddr, wdata, raddr, rdata, irq_vector;
  logic        wenable, cpu_irq, cpu_reset_irq, in_service;
  logic [2:0]  irq_id;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  irq_arbiter dut (
    .clock(clock), .reset(reset), .src_irq(src_irq),
    .waddr(waddr), .wdata(wdata), .wenable(wenable),
    .raddr(raddr), .rdata(rdata), .cpu_irq(cpu_irq),
    .cpu_reset_irq(cpu_reset_irq), .irq_vector(irq_vector),
    .irq_id(irq_id), .in_service(in_service)
  );

  // Reference model: 0 = idle, 1 = request presented, 2 = handler running.
  int         m_phase;
  int         m_id;
  int         m_since_reset;
  logic [3:0] m_mask, m_pend, m_prev;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [15:0] exp_read(input logic [15:0] a);
    if (a == A_MASK) return {12'b0, m_mask};
    if (a == A_PEND) return {12'b0, m_pend};
    if (a == A_ID)   return 16'(m_id);
    return 16'h0;
  endfunction

  function automatic logic [15:0] exp_vec();
    if (m_phase == 0) return 16'h0;
    return 16'((256 + m_id * 16) % 65536);
  endfunction

  task automatic model_step();
    logic [3:0] rise, w1c, nmask, npend, bit_id;
    int nphase;
    if (reset) begin
      m_phase = 0; m_id = 0; m_mask = 0; m_pend = 0; m_prev = 0;
      m_since_reset = 0;
      return;
    end
    rise   = (m_since_reset > 0) ? (src_irq & ~m_prev) : 4'h0;
    w1c    = (wenable && waddr == A_PEND) ? wdata[3:0] : 4'h0;
    nmask  = (wenable && waddr == A_MASK) ? wdata[3:0] : m_mask;
    npend  = (m_pend & ~w1c) | rise;
    nphase = m_phase;
    if (m_phase == 0) begin
      if ((m_pend & m_mask) != 0) begin
        m_id   = lowest(m_pend & m_mask);
        nphase = 1;
      end
    end else if (m_phase == 1) begin
      bit_id = 4'h1 << m_id;
      if (cpu_reset_irq) begin
        npend  = (npend & ~bit_id) | (rise & bit_id);
        nphase = 2;
      end else if ((npend & bit_id) == 0 || (nmask & bit_id) == 0) begin
        nphase = 0;
      end
    end else if (wenable && waddr == A_EOI) begin
      nphase = 0;
    end
    m_phase = nphase;
    m_mask  = nmask;
    m_pend  = npend;
    m_prev  = src_irq;
    if (m_since_reset < 1000) m_since_reset++;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later,
  // then return at the falling edge ready for the next drive.
  task automatic run_cycle(input string tag);
    @(posedge clock);
    model_step();
    #1;
    $display("%s rst=%0b src=%h wen=%0b waddr=%h wdata=%h ack=%0b raddr=%h -> irq=%0b id=%0d vec=%h svc=%0b rdata=%h",
             tag, reset, src_irq, wenable, waddr, wdata, cpu_reset_irq, raddr,
             cpu_irq, irq_id, irq_vector, in_service, rdata);
    chk({tag, ".m.cpu_irq"},    {15'b0, cpu_irq},    {15'b0, m_phase == 1});
    chk({tag, ".m.in_service"}, {15'b0, in_service}, {15'b0, m_phase == 2});
    chk({tag, ".m.irq_id"},     {13'b0, irq_id},     16'(m_id));
    chk({tag, ".m.irq_vector"}, irq_vector,          exp_vec());
    chk({tag, ".m.rdata"},      rdata,               exp_read(raddr));
    @(negedge clock);
  endtask

  task automatic drive(input logic rst, input logic [3:0] src, input logic wen,
                       input logic [15:0] wa, input logic [15:0] wd,
                       input logic ack, input logic [15:0] ra);
    reset = rst; src_irq = src; wenable = wen; waddr = wa; wdata = wd;
    cpu_reset_irq = ack; raddr = ra;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  src;
    logic        wen;
    logic [15:0] wa;
    logic [15:0] wd;
    logic        ack;
    logic [15:0] ra;
    logic        e_irq;
    logic [2:0]  e_id;
    logic [15:0] e_vec;
    logic        e_svc;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] src, input logic wen,
                     input logic [15:0] wa, input logic [15:0] wd, input logic ack,
                     input logic [15:0] ra, input logic e_irq, input logic [2:0] e_id,
                     input logic [15:0] e_vec, input logic e_svc, input logic [15:0] e_rdata);
    vec_t v;
    v.rst = rst; v.src = src; v.wen = wen; v.wa = wa; v.wd = wd; v.ack = ack;
    v.ra = ra; v.e_irq = e_irq; v.e_id = e_id; v.e_vec = e_vec; v.e_svc = e_svc;
    v.e_rdata = e_rdata;
    tbl.push_back(v);
  endtask

  initial begin
    string tag;
    //   rst src  wen addr    data     ack raddr   irq id vec      svc rdata
    // mask all, pulse src 2
    add(0, 4'h0, 1, A_MASK, 16'h000F, 0, A_MASK, 0, 0, 16'h0000, 0, 16'h000F);
    add(0, 4'h4, 0, 16'h0,  16'h0000, 0, A_PEND, 0, 0, 16'h0000, 0, 16'h0004);
    add(0, 4'h0, 0, 16'h0,  16'h0000, 0, A_ID,   1, 2, 16'h0120, 0, 16'h0002);
    add(0, 4'h0, 0, 16'h0,  16'h0000, 1, A_PEND, 0, 2, 16'h0120, 1, 16'h0000);
    add(0, 4'h0, 1, A_EOI,  16'h0000, 0, A_EOI,  0, 2, 16'h0000, 0, 16'h0000);
    // src 1 and 3 together: 1 first, then 3 after EOI
    add(0, 4'hA, 0, 16'h0,  16'h0000, 0, A_PEND, 0, 2, 16'h0000, 0, 16'h000A);
    add(0, 4'h0, 0, 16'h0,  16'h0000, 0, A_ID,   1, 1, 16'h0110, 0, 16'h0001);
    add(0, 4'h0, 0, 16'h0,  16'h0000, 1, A_PEND, 0, 1, 16'h0110, 1, 16'h0008);
    add(0, 4'h0, 1, A_EOI,  16'h1234, 0, A_ID,   0, 1, 16'h0000, 0, 16'h0001);
    add(0, 4'h0, 0, 16'h0,  16'h0000, 0, A_ID,   1, 3, 16'h0130, 0, 16'h0003);
    add(0, 4'h0, 0, 16'h0,  16'h0000, 1, A_PEND, 0, 3, 16'h0130, 1, 16'h0000);
    add(0, 4'h0, 1, A_EOI,  16'h0000, 0, A_MASK, 0, 3, 16'h0000, 0, 16'h000F);
    // masked source stays pending until enabled
    add(0, 4'h0, 1, A_MASK, 16'h000E, 0, A_MASK, 0, 3, 16'h0000, 0, 16'h000E);
    add(0, 4'h1, 0, 16'h0,  16'h0000, 0, A_PEND, 0, 3, 16'h0000, 0, 16'h0001);
    add(0, 4'h0, 0, 16'h0,  16'h0000, 0, A_PEND, 0, 3, 16'h0000, 0, 16'h0001);
    add(0, 4'h0, 1, A_MASK, 16'h0001, 0, A_MASK, 0, 3, 16'h0000, 0, 16'h0001);
    add(0, 4'h0, 0, 16'h0,  16'h0000, 0, A_ID,   1, 0, 16'h0100, 0, 16'h0000);
    // new request during service waits for EOI
    add(0, 4'h0, 0, 16'h0,  16'h0000, 1, A_PEND, 0, 0, 16'h0100, 1, 16'h0000);
    add(0, 4'h1, 0, 16'h0,  16'h0000, 0, A_PEND, 0, 0, 16'h0100, 1, 16'h0001);
    add(0, 4'h0, 0, 16'h0,  16'h0000, 0, A_PEND, 0, 0, 16'h0100, 1, 16'h0001);
    add(0, 4'h0, 1, A_EOI,  16'h0000, 0, A_PEND, 0, 0, 16'h0000, 0, 16'h0001);
    add(0, 4'h0, 0, 16'h0,  16'h0000, 0, A_ID,   1, 0, 16'h0100, 0, 16'h0000);
    // W1C of the presented request withdraws it without an ack
    add(0, 4'h0, 1, A_PEND, 16'h0001, 0, A_PEND, 0, 0, 16'h0000, 0, 16'h0000);
    add(0, 4'h0, 0, 16'h0,  16'h0000, 0, A_PEND, 0, 0, 16'h0000, 0, 16'h0000);
    // reset during service with all sources held high
    add(0, 4'hF, 0, 16'h0,  16'h0000, 0, A_PEND, 0, 0, 16'h0000, 0, 16'h000F);
    add(0, 4'hF, 0, 16'h0,  16'h0000, 0, A_ID,   1, 0, 16'h0100, 0, 16'h0000);
    add(0, 4'hF, 0, 16'h0,  16'h0000, 1, A_PEND, 0, 0, 16'h0100, 1, 16'h000E);
    add(1, 4'hF, 0, 16'h0,  16'h0000, 0, A_PEND, 0, 0, 16'h0000, 0, 16'h0000);
    add(0, 4'hF, 0, 16'h0,  16'h0000, 0, A_PEND, 0, 0, 16'h0000, 0, 16'h0000);
    add(0, 4'hF, 0, 16'h0,  16'h0000, 0, A_PEND, 0, 0, 16'h0000, 0, 16'h0000);
    add(0, 4'hF, 1, A_MASK, 16'h000F, 0, A_MASK, 0, 0, 16'h0000, 0, 16'h000F);
    add(0, 4'hF, 0, 16'h0,  16'h0000, 0, A_ID,   0, 0, 16'h0000, 0, 16'h0000);

    // Power-on reset
    drive(1, 4'h0, 0, 16'h0, 16'h0, 0, A_MASK);
    run_cycle("reset0");
    run_cycle("reset1");
    chk("reset.cpu_irq",    {15'b0, cpu_irq},    16'h0);
    chk("reset.in_service", {15'b0, in_service}, 16'h0);
    chk("reset.irq_vector", irq_vector,          16'h0);
    chk("reset.irq_id",     {13'b0, irq_id},     16'h0);
    for (int r = 0; r < 4; r++) begin
      raddr = A_MASK + 16'(r);
      #1;
      chk($sformatf("reset.rdata%0d", r), rdata, 16'h0);
    end
    drive(0, 4'h0, 0, 16'h0, 16'h0, 0, A_MASK);
    run_cycle("idle0");
    run_cycle("idle1");

    // Directed vector table
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].rst, tbl[k].src, tbl[k].wen, tbl[k].wa, tbl[k].wd, tbl[k].ack, tbl[k].ra);
      tag = $sformatf("vec%0d", k);
      run_cycle(tag);
      chk({tag, ".cpu_irq"},    {15'b0, cpu_irq},    {15'b0, tbl[k].e_irq});
      chk({tag, ".irq_id"},     {13'b0, irq_id},     {13'b0, tbl[k].e_id});
      chk({tag, ".irq_vector"}, irq_vector,          tbl[k].e_vec);
      chk({tag, ".in_service"}, {15'b0, in_service}, {15'b0, tbl[k].e_svc});
      chk({tag, ".rdata"},      rdata,               tbl[k].e_rdata);
    end

    // Hand sequence: an edge beats a same-cycle W1C, and a same-cycle ack.
    drive(0, 4'h0, 0, 16'h0, 16'h0, 0, A_PEND);
    run_cycle("hs0");
    drive(0, 4'h1, 1, A_PEND, 16'h0001, 0, A_PEND);
    run_cycle("hs1");
    chk("hs1.set_beats_w1c", rdata, 16'h0001);
    drive(0, 4'h1, 0, 16'h0, 16'h0, 0, A_ID);
    run_cycle("hs2");
    chk("hs2.cpu_irq", {15'b0, cpu_irq}, 16'h1);
    drive(0, 4'h0, 0, 16'h0, 16'h0, 0, A_PEND);
    run_cycle("hs3");
    drive(0, 4'h1, 0, 16'h0, 16'h0, 1, A_PEND);
    run_cycle("hs4");
    chk("hs4.set_beats_ack", rdata, 16'h0001);
    chk("hs4.in_service", {15'b0, in_service}, 16'h1);
    drive(0, 4'h1, 0, 16'h0, 16'h0, 1, A_PEND);
    run_cycle("hs5");
    chk("hs5.ack_ignored_in_service", rdata, 16'h0001);
    drive(0, 4'h1, 1, A_EOI, 16'h0, 0, A_ID);
    run_cycle("hs6");
    chk("hs6.eoi_idle", {15'b0, cpu_irq}, 16'h0);
    drive(0, 4'h1, 0, 16'h0, 16'h0, 0, A_ID);
    run_cycle("hs7");
    chk("hs7.regrant", {15'b0, cpu_irq}, 16'h1);
    chk("hs7.vector", irq_vector, 16'h0100);

    // Randomized run against the model
    for (int n = 0; n < 1000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) src_irq = 4'($urandom);
      wenable = ($urandom_range(0, 3) == 0);
      waddr   = ($urandom_range(0, 9) == 0) ? 16'($urandom) : A_MASK + 16'($urandom_range(0, 4));
      wdata   = 16'($urandom);
      cpu_reset_irq = ($urandom_range(0, 2) == 0);
      raddr   = ($urandom_range(0, 9) == 0) ? 16'($urandom) : A_MASK + 16'($urandom_range(0, 5));
      run_cycle($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
